// File: rtl/toy_pack.sv
// Shared front-end types and constants.
// Covers the commit-side RAS record and the BPU redirect bundle.
package toy_pack;

  localparam int ADDR_WIDTH = 32;
  localparam int OFS_WIDTH  = 4;
  localparam int RAS_DEPTH  = 16;

  localparam logic [1:0] RAS_INST_NONE = 2'b00;
  localparam logic [1:0] RAS_INST_CALL = 2'b01;
  localparam logic [1:0] RAS_INST_RET  = 2'b10;
  localparam logic [1:0] RAS_INST_SWAP = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] RAS_INC_C = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] RAS_INC_I = ADDR_WIDTH'(4);

  typedef struct packed {
    logic [1:0]            inst_type;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pred_pc;
    logic [OFS_WIDTH-1:0]  offset;
    logic                  is_cext;
    logic                  carry;
    logic [ADDR_WIDTH-1:0] tgt_pc;
  } ras_pkg;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pred_pc;
    logic [ADDR_WIDTH-1:0] tgt_pc;
    logic                  taken;
    logic [OFS_WIDTH-1:0]  offset;
    logic                  is_cext;
    logic                  carry;
    logic                  need_align;
  } bpu_pkg;

  // Wraps naturally at the top of the address space.
  function automatic logic [ADDR_WIDTH-1:0] ras_ret_addr(
    input logic [ADDR_WIDTH-1:0] pc,
    input logic                  cext
  );
    return pc + (cext ? RAS_INC_C : RAS_INC_I);
  endfunction

endpackage

// File: rtl/toy_fe_ras_stack.sv
// Circular LIFO for return addresses.
// push+pop together overwrites the top slot in place.
module toy_fe_ras_stack #(
  parameter  int DEPTH = 16,
  parameter  int AW    = 32,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] wdata_i,
  output logic [AW-1:0] top_o,
  output logic [PW:0]   count_o
);

  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW:0]   cnt_q;
  logic [PW:0]   cnt_d;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] wr_idx;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign top_idx = ptr_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL);
  assign do_push = push_i & ~pop_i;
  assign do_pop  = pop_i & ~push_i & ~empty;
  assign wr_idx  = pop_i ? top_idx : ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      do_push: begin
        ptr_d = ptr_q + PW'(1);
        if (!full) cnt_d = cnt_q + (PW+1)'(1);
      end
      do_pop: begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - (PW+1)'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; reads are gated by count upstream.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_idx] <= wdata_i;
  end

  assign top_o   = mem_q[top_idx];
  assign count_o = cnt_q;

endmodule

// File: rtl/toy_fe_ras.sv
// Commit-side return address stack.
// Issues a registered redirect when a committed return mispredicted.
module toy_fe_ras
  import toy_pack::*;
#(
  parameter  int RAS_DEPTH = toy_pack::RAS_DEPTH,
  localparam int PTR_WIDTH = $clog2(RAS_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ras_flush,
  input  logic               ras_vld,
  input  ras_pkg             ras_pld,
  output logic               ras_chgflw_vld,
  output bpu_pkg             ras_chgflw_pld,
  output logic [PTR_WIDTH:0] ras_depth_o
);

  logic [ADDR_WIDTH-1:0] top;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic [PTR_WIDTH:0]    cnt;
  logic                  push;
  logic                  pop;
  logic                  redir;
  logic                  vld_q;
  bpu_pkg                pld_d;
  bpu_pkg                pld_q;

  assign push     = ras_vld & ras_pld.inst_type[0];
  assign pop      = ras_vld & ras_pld.inst_type[1];
  assign ret_addr = ras_ret_addr(ras_pld.pc, ras_pld.is_cext);

  toy_fe_ras_stack #(
    .DEPTH (RAS_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (ret_addr),
    .top_o   (top),
    .count_o (cnt)
  );

  always_comb begin
    redir = pop & (cnt != '0) & (top != ras_pld.tgt_pc) & ~ras_flush;
    pld_d = '0;
    if (redir) begin
      pld_d.pred_pc    = ras_pld.pred_pc;
      pld_d.tgt_pc     = top;
      pld_d.taken      = 1'b1;
      pld_d.offset     = ras_pld.offset;
      pld_d.is_cext    = ras_pld.is_cext;
      pld_d.carry      = ras_pld.carry;
      pld_d.need_align = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pld_q <= '0;
    end else begin
      vld_q <= redir;
      pld_q <= pld_d;
    end
  end

  // A backend cancel also kills the redirect already in flight.
  assign ras_chgflw_vld = vld_q & ~ras_flush;
  assign ras_chgflw_pld = pld_q;
  assign ras_depth_o    = cnt;

endmodule

// File: tb/tb_toy_fe_ras.sv
// Scoreboard bench for toy_fe_ras.
// A reference stack predicts redirects one cycle ahead.
module tb_toy_fe_ras;
  import toy_pack::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ras_flush = 1'b0;
  logic       ras_vld = 1'b0;
  ras_pkg     ras_pld = '0;
  logic       ras_chgflw_vld;
  bpu_pkg     ras_chgflw_pld;
  logic [4:0] ras_depth_o;

  toy_fe_ras dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ras_flush      (ras_flush),
    .ras_vld        (ras_vld),
    .ras_pld        (ras_pld),
    .ras_chgflw_vld (ras_chgflw_vld),
    .ras_chgflw_pld (ras_chgflw_pld),
    .ras_depth_o    (ras_depth_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   vld;
    bpu_pkg pld;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_stk [16];
  int          m_ptr = 0;
  int          m_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_top();
    return m_stk[(m_ptr + 15) % 16];
  endfunction

  task automatic cyc(input logic rst, input logic vld,
                     input logic [1:0] typ, input logic [31:0] pc,
                     input logic [31:0] pred, input logic [31:0] tgt,
                     input logic cext, input logic flush);
    exp_t        e;
    logic [31:0] top;
    logic [31:0] ra;
    @(negedge clk);
    rst_n             = rst;
    ras_vld           = vld;
    ras_flush         = flush;
    ras_pld.inst_type = typ;
    ras_pld.pc        = pc;
    ras_pld.pred_pc   = pred;
    ras_pld.offset    = pc[4:1];
    ras_pld.is_cext   = cext;
    ras_pld.carry     = pc[5];
    ras_pld.tgt_pc    = tgt;
    #1;
    e.vld = 1'b0;
    e.pld = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    chk("vld", 80'(ras_chgflw_vld), 80'(e.vld & ~flush));
    if (e.vld & ~flush)
      chk("pld", 80'(ras_chgflw_pld), 80'(e.pld));
    chk("depth", 80'(ras_depth_o), 80'(m_cnt));
    top   = m_top();
    ra    = pc + (cext ? 32'd2 : 32'd4);
    e.vld = 1'b0;
    e.pld = '0;
    if (!rst) begin
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      if (vld && typ[1] && m_cnt != 0 && top != tgt && !flush) begin
        e.vld            = 1'b1;
        e.pld.pred_pc    = pred;
        e.pld.tgt_pc     = top;
        e.pld.taken      = 1'b1;
        e.pld.offset     = pc[4:1];
        e.pld.is_cext    = cext;
        e.pld.carry      = pc[5];
        e.pld.need_align = 1'b0;
      end
      if (vld) begin
        case (typ)
          2'b01: begin
            m_stk[m_ptr] = ra;
            m_ptr = (m_ptr + 1) % 16;
            if (m_cnt < 16) m_cnt++;
          end
          2'b10: begin
            if (m_cnt > 0) begin
              m_ptr = (m_ptr + 15) % 16;
              m_cnt--;
            end
          end
          2'b11: m_stk[(m_ptr + 15) % 16] = ra;
          default: ;
        endcase
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic flush);
    cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, flush);
  endtask

  task automatic call(input logic [31:0] pc, input logic cext);
    cyc(1'b1, 1'b1, RAS_INST_CALL, pc, 32'h0, 32'h0, cext, 1'b0);
  endtask

  task automatic ret(input logic [31:0] pred, input logic [31:0] tgt,
                     input logic flush);
    cyc(1'b1, 1'b1, RAS_INST_RET, 32'h0, pred, tgt, 1'b0, flush);
  endtask

  initial begin
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_pld", 80'(ras_chgflw_pld), 80'h0);

    call(32'h8000_0010, 1'b0);
    idle(1'b0);
    chk("t1_d1", 80'(ras_depth_o), 80'd1);
    ret(32'h0, 32'h8000_0014, 1'b0);
    idle(1'b0);
    chk("t1_vld", 80'(ras_chgflw_vld), 80'd0);
    chk("t1_d0", 80'(ras_depth_o), 80'd0);

    call(32'h8000_0020, 1'b1);
    ret(32'h8000_0080, 32'h8000_0100, 1'b0);
    idle(1'b0);
    chk("t2_vld", 80'(ras_chgflw_vld), 80'd1);
    chk("t2_tgt", 80'(ras_chgflw_pld.tgt_pc), 80'h8000_0022);
    chk("t2_pred", 80'(ras_chgflw_pld.pred_pc), 80'h8000_0080);
    chk("t2_taken", 80'(ras_chgflw_pld.taken), 80'd1);

    for (int i = 0; i < 17; i++) call(32'h100 + 32'(4 * i), 1'b0);
    idle(1'b0);
    chk("t3_sat", 80'(ras_depth_o), 80'd16);
    for (int k = 0; k < 16; k++) ret(32'h0, m_top(), 1'b0);
    ret(32'h0, 32'hDEAD_0000, 1'b0);
    idle(1'b0);
    chk("t3_uf_vld", 80'(ras_chgflw_vld), 80'd0);
    chk("t3_uf_d", 80'(ras_depth_o), 80'd0);

    call(32'h400, 1'b0);
    ret(32'h0, 32'h999, 1'b1);
    idle(1'b0);
    chk("t4_vld", 80'(ras_chgflw_vld), 80'd0);
    chk("t4_d", 80'(ras_depth_o), 80'd0);
    call(32'h400, 1'b0);
    ret(32'h0, 32'h999, 1'b0);
    idle(1'b1);
    chk("t4_kill", 80'(ras_chgflw_vld), 80'd0);

    call(32'h1FC, 1'b0);
    cyc(1'b1, 1'b1, RAS_INST_SWAP, 32'h300, 32'h0, 32'h200, 1'b0, 1'b0);
    idle(1'b0);
    chk("t5_vld", 80'(ras_chgflw_vld), 80'd0);
    chk("t5_d", 80'(ras_depth_o), 80'd1);
    ret(32'h0, 32'h304, 1'b0);
    idle(1'b0);
    chk("t5_top", 80'(ras_chgflw_vld), 80'd0);

    call(32'hFFFF_FFFE, 1'b1);
    ret(32'h50, 32'h4, 1'b0);
    idle(1'b0);
    chk("t6_vld", 80'(ras_chgflw_vld), 80'd1);
    chk("t6_wrap", 80'(ras_chgflw_pld.tgt_pc), 80'h0);

    call(32'h600, 1'b0);
    call(32'h700, 1'b0);
    ret(32'h0, 32'h1, 1'b0);
    ret(32'h0, 32'h2, 1'b0);
    chk("t7_p1", 80'(ras_chgflw_vld), 80'd1);
    idle(1'b0);
    chk("t7_p2", 80'(ras_chgflw_vld), 80'd1);

    call(32'h800, 1'b0);
    cyc(1'b0, 1'b1, RAS_INST_RET, 32'h0, 32'h0, 32'h3, 1'b0, 1'b0);
    idle(1'b0);
    chk("t8_vld", 80'(ras_chgflw_vld), 80'd0);
    chk("t8_d", 80'(ras_depth_o), 80'd0);

    for (int r = 0; r < 300; r++) begin
      logic [1:0]  typ;
      logic [31:0] pc;
      logic [31:0] tgt;
      typ = 2'($urandom_range(0, 3));
      pc  = $urandom & 32'hFFFF_FFFE;
      tgt = ($urandom_range(0, 1) == 1) ? m_top() : $urandom;
      cyc(1'b1, ($urandom_range(0, 3) != 0), typ, pc, $urandom, tgt,
          1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end
    idle(1'b0);
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
